serial_word_receiver: RTL

SERIAL_WORD_RECEIVER -- requirements
Module: serial_word_receiver

---
 rtl/serial_word_receiver.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/serial_word_receiver.sv
// rtl/serial_word_receiver.sv - serial-to-parallel word receiver with output holding register
//
// Purpose: assembles WIDTH serial bits into a word, in the bit order chosen by dir
//          when the frame starts. Each completed word is offered to a single-entry
//          output register with a valid/ready handshake.
//
// Ports:
//   clk          in   clock; all state updates on the rising edge
//   reset        in   synchronous active-high reset
//   serial_in    in   serial data bit, sampled only while bit_valid=1
//   bit_valid    in   serial_in qualifier
//   frame_start  in   pulse that starts or restarts a word
//   dir          in   0 = LSB-first (shift right), 1 = MSB-first (shift left)
//   out_ready    in   consumer accepts parallel_out while out_valid=1
//   parallel_out out  last accepted word (registered)
//   out_valid    out  parallel_out holds an unconsumed word
//   busy         out  high while a word is being shifted in
//   bit_count    out  number of bits accepted in the current word
//   overrun      out  sticky flag: a completed word was dropped

module serial_word_receiver #(
   parameter int WIDTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         serial_in,
   input  logic                         bit_valid,
   input  logic                         frame_start,
   input  logic                         dir,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             parallel_out,
   output logic                         out_valid,
   output logic                         busy,
   output logic [$clog2(WIDTH+1)-1:0]   bit_count,
   output logic                         overrun
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  shreg_q, shreg_d;
   logic              dir_q, dir_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  pout_q, pout_d;
   logic              ovalid_q, ovalid_d;
   logic              overrun_q, overrun_d;

   // Word completion and the value of the completed word, both valid this cycle
   logic              word_done;
   logic [WIDTH-1:0]  word_val;

   // Shift helpers: the bit order used for a word is fixed at frame_start
   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                 input logic             msb_first,
                                                 input logic             b);
      logic [WIDTH-1:0] res;
      if (msb_first) begin
         res = {cur[WIDTH-2:0], b};
      end else begin
         res = {b, cur[WIDTH-1:1]};
      end
      return res;
   endfunction

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (frame_start) begin
         // A restart always lands in SHIFT; WIDTH >= 2 means one bit cannot finish a word
         state_d = ST_SHIFT;
      end else if (state_q == ST_SHIFT && bit_valid && cnt_q == LAST_IDX) begin
         state_d = ST_IDLE;
      end
   end

   // ---------------------------------------------------------------------
   // Output logic
   // ---------------------------------------------------------------------
   always_comb begin
      busy = (state_q == ST_SHIFT);
   end

   // ---------------------------------------------------------------------
   // Shift datapath
   // ---------------------------------------------------------------------
   always_comb begin
      shreg_d   = shreg_q;
      dir_d     = dir_q;
      cnt_d     = cnt_q;
      word_done = 1'b0;
      word_val  = shreg_q;

      if (frame_start) begin
         // Restart discards any partial word; a bit arriving with the pulse
         // becomes bit 0 of the new word, ordered by the freshly latched dir.
         dir_d = dir;
         if (bit_valid) begin
            shreg_d = shift_in('0, dir, serial_in);
            cnt_d   = CW'(1);
         end else begin
            shreg_d = '0;
            cnt_d   = '0;
         end
      end else if (state_q == ST_SHIFT && bit_valid) begin
         word_val = shift_in(shreg_q, dir_q, serial_in);
         shreg_d  = word_val;
         if (cnt_q == LAST_IDX) begin
            word_done = 1'b1;
            cnt_d     = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Output holding register and overrun flag
   // ---------------------------------------------------------------------
   always_comb begin
      pout_d    = pout_q;
      ovalid_d  = ovalid_q;
      overrun_d = overrun_q;

      if (word_done) begin
         if (!ovalid_q || out_ready) begin
            pout_d   = word_val;
            ovalid_d = 1'b1;
         end else begin
            // Unconsumed word still held: keep it and drop the new one
            overrun_d = 1'b1;
         end
      end else if (ovalid_q && out_ready) begin
         ovalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg_q   <= '0;
         dir_q     <= 1'b0;
         cnt_q     <= '0;
         pout_q    <= '0;
         ovalid_q  <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         shreg_q   <= shreg_d;
         dir_q     <= dir_d;
         cnt_q     <= cnt_d;
         pout_q    <= pout_d;
         ovalid_q  <= ovalid_d;
         overrun_q <= overrun_d;
      end
   end

   assign parallel_out = pout_q;
   assign out_valid    = ovalid_q;
   assign bit_count    = cnt_q;
   assign overrun      = overrun_q;

endmodule
